fwd_hazard_unit: RTL and testbench

- Parametrised successor to the pipeline forwarding logic.
- Generalises operand forwarding to NUM_SRC source operands and N_FWD later pipeline stages, with youngest-stage-wins priority.
- Adds load-use stall detection and a registered scoreboard for long-latency (multi-cycle divide/CSR) writebacks.
- Adds a saturating stall-cycle performance counter. Sits between the ID/EX pipeline registers and the EX operand muxes.

---
 rtl/fwd_hazard_unit.sv | 108 ++++++++++
 tb/tb_fwd_hazard_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, load-use and long-latency scoreboard hazard detection
// for the EX stage, with a saturating stall-cycle counter.
module fwd_hazard_unit #(
  parameter int unsigned AW      = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned N_FWD   = 2,
  parameter int unsigned SELW    = $clog2(N_FWD + 1),
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*AW-1:0]     rs_ex,
  input  logic [N_FWD*AW-1:0]       rd_stg,
  input  logic [N_FWD-1:0]          regwen_stg,
  input  logic [NUM_SRC*AW-1:0]     rs_id,
  input  logic [NUM_SRC-1:0]        rs_used_id,
  input  logic [AW-1:0]             rd_id,
  input  logic                      regwen_id,
  input  logic [AW-1:0]             rd_ex,
  input  logic                      memrd_ex,
  input  logic                      regwen_ex,
  input  logic                      lat_issue,
  input  logic [AW-1:0]             lat_issue_rd,
  input  logic                      lat_done,
  input  logic [AW-1:0]             lat_done_rd,
  output logic [NUM_SRC*SELW-1:0]   fwd_sel,
  output logic                      stall_if,
  output logic                      stall_id,
  output logic                      bubble_ex,
  output logic [(2**AW)-1:0]        pending,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int unsigned NREG = 2**AW;

  logic [NUM_SRC*SELW-1:0] w_fwd_sel;
  logic                    w_lu_match;
  logic                    w_sb_src;
  logic                    w_load_use;
  logic                    w_waw;
  logic                    w_stall;
  logic [NREG-1:0]         w_pending_nxt;
  logic [NREG-1:0]         r_pending;
  logic [CNT_W-1:0]        r_cnt;

  // Oldest stage is visited first so the youngest matching stage overwrites it.
  always_comb begin
    w_fwd_sel = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      for (int k = int'(N_FWD) - 1; k >= 0; k--) begin
        if (regwen_stg[k] && (rd_stg[k*AW +: AW] != '0) &&
            (rd_stg[k*AW +: AW] == rs_ex[i*AW +: AW])) begin
          w_fwd_sel[i*SELW +: SELW] = SELW'(k + 1);
        end
      end
    end
  end

  // ID source hits on the EX load destination and on pending long-latency results.
  always_comb begin
    w_lu_match = 1'b0;
    w_sb_src   = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (rs_used_id[i] && (rs_id[i*AW +: AW] == rd_ex)) begin
        w_lu_match = 1'b1;
      end
      if (rs_used_id[i] && (rs_id[i*AW +: AW] != '0) && r_pending[rs_id[i*AW +: AW]]) begin
        w_sb_src = 1'b1;
      end
    end
  end

  assign w_load_use = memrd_ex & regwen_ex & (rd_ex != '0) & w_lu_match;
  assign w_waw      = regwen_id & (rd_id != '0) & r_pending[rd_id];
  assign w_stall    = ~reset & (w_load_use | w_sb_src | w_waw);

  assign fwd_sel   = reset ? '0 : w_fwd_sel;
  assign stall_if  = w_stall;
  assign stall_id  = w_stall;
  assign bubble_ex = w_stall;
  assign pending   = r_pending;
  assign stall_cnt = r_cnt;

  // Issue is applied after completion so a same-register collision stays pending.
  always_comb begin
    w_pending_nxt = r_pending;
    if (lat_done) begin
      w_pending_nxt[lat_done_rd] = 1'b0;
    end
    if (lat_issue) begin
      w_pending_nxt[lat_issue_rd] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
      r_cnt     <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_stall && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomized and directed checks of fwd_hazard_unit against a behavioural model;
// a second instance with a 4-bit counter exercises counter saturation.
module tb_fwd_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rs_ex, rd_stg, rs_id;
  logic [1:0]  regwen_stg, rs_used_id;
  logic [4:0]  rd_id, rd_ex, lat_issue_rd, lat_done_rd;
  logic        regwen_id, memrd_ex, regwen_ex, lat_issue, lat_done;

  logic [3:0]  fwd_sel, fwd_sel_s;
  logic        stall_if, stall_id, bubble_ex;
  logic        stall_if_s, stall_id_s, bubble_ex_s;
  logic [31:0] pending, pending_s;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt_s;

  int n_tests = 0;
  int n_fail  = 0;

  bit [31:0] m_pend;
  int        m_cnt, m_cnt_s;

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk(clk), .reset(reset), .rs_ex(rs_ex), .rd_stg(rd_stg), .regwen_stg(regwen_stg),
    .rs_id(rs_id), .rs_used_id(rs_used_id), .rd_id(rd_id), .regwen_id(regwen_id),
    .rd_ex(rd_ex), .memrd_ex(memrd_ex), .regwen_ex(regwen_ex),
    .lat_issue(lat_issue), .lat_issue_rd(lat_issue_rd),
    .lat_done(lat_done), .lat_done_rd(lat_done_rd),
    .fwd_sel(fwd_sel), .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .pending(pending), .stall_cnt(stall_cnt)
  );

  fwd_hazard_unit #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .rs_ex(rs_ex), .rd_stg(rd_stg), .regwen_stg(regwen_stg),
    .rs_id(rs_id), .rs_used_id(rs_used_id), .rd_id(rd_id), .regwen_id(regwen_id),
    .rd_ex(rd_ex), .memrd_ex(memrd_ex), .regwen_ex(regwen_ex),
    .lat_issue(lat_issue), .lat_issue_rd(lat_issue_rd),
    .lat_done(lat_done), .lat_done_rd(lat_done_rd),
    .fwd_sel(fwd_sel_s), .stall_if(stall_if_s), .stall_id(stall_id_s), .bubble_ex(bubble_ex_s),
    .pending(pending_s), .stall_cnt(stall_cnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int src(input logic [9:0] v, input int i);
    return int'(v[i*5 +: 5]);
  endfunction

  // Youngest forwarding stage holding the operand, 0 if none or operand is x0.
  function automatic int exp_fwd(input int i);
    int a = src(rs_ex, i);
    if (reset || a == 0) return 0;
    for (int k = 0; k < 2; k++)
      if (regwen_stg[k] && src(rd_stg, k) == a) return k + 1;
    return 0;
  endfunction

  function automatic bit exp_stall();
    bit lu = 1'b0;
    bit sb = 1'b0;
    if (reset) return 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (memrd_ex && regwen_ex && rd_ex != 0 && rs_used_id[i] && src(rs_id, i) == int'(rd_ex))
        lu = 1'b1;
      if (rs_used_id[i] && src(rs_id, i) != 0 && m_pend[src(rs_id, i)])
        sb = 1'b1;
    end
    if (regwen_id && rd_id != 0 && m_pend[rd_id]) sb = 1'b1;
    return lu | sb;
  endfunction

  task automatic check_all();
    logic [3:0] ef;
    bit         es;
    ef = {2'(exp_fwd(1)), 2'(exp_fwd(0))};
    es = exp_stall();
    chk("fwd_sel", 32'(fwd_sel), 32'(ef));
    chk("fwd_sel_s", 32'(fwd_sel_s), 32'(ef));
    chk("stall_if", 32'(stall_if), 32'(es));
    chk("stall_id", 32'(stall_id), 32'(es));
    chk("bubble_ex", 32'(bubble_ex), 32'(es));
    chk("stall_id_s", 32'(stall_id_s & stall_if_s & bubble_ex_s), 32'(es));
    chk("pending", pending, m_pend);
    chk("pending_s", pending_s, m_pend);
    chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    chk("stall_cnt_s", 32'(stall_cnt_s), 32'(m_cnt_s));
  endtask

  task automatic model_edge();
    bit st = exp_stall();
    if (reset) begin
      m_pend = '0; m_cnt = 0; m_cnt_s = 0;
    end else begin
      if (st) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 15) m_cnt_s++;
      end
      if (lat_done)  m_pend[lat_done_rd]  = 1'b0;
      if (lat_issue) m_pend[lat_issue_rd] = 1'b1;
      m_pend[0] = 1'b0;
    end
  endtask

  // Check the current cycle mid-period, then advance the model across the edge.
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rs_ex = '0; rd_stg = '0; regwen_stg = '0; rs_id = '0; rs_used_id = '0;
    rd_id = '0; regwen_id = 1'b0; rd_ex = '0; memrd_ex = 1'b0; regwen_ex = 1'b0;
    lat_issue = 1'b0; lat_issue_rd = '0; lat_done = 1'b0; lat_done_rd = '0;
  endtask

  initial begin
    m_pend = '0; m_cnt = 0; m_cnt_s = 0;
    idle_inputs();
    reset = 1'b1;
    // Reset must mask forwarding and hazards even with matching inputs.
    rs_ex = {5'd0, 5'd5}; rd_stg = {5'd5, 5'd5}; regwen_stg = 2'b11;
    memrd_ex = 1'b1; regwen_ex = 1'b1; rd_ex = 5'd5; rs_id = {5'd5, 5'd5}; rs_used_id = 2'b11;
    tick();
    tick();
    #1;
    chk("rst_fwd", 32'(fwd_sel), 32'd0);
    chk("rst_stall", 32'(stall_id), 32'd0);
    chk("rst_pending", pending, 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    reset = 1'b0;
    idle_inputs();

    // Forwarding priority
    rs_ex = {5'd0, 5'd5}; rd_stg = {5'd5, 5'd5}; regwen_stg = 2'b11;
    #1 chk("fwd_ma_wins", 32'(fwd_sel), 32'd1);
    tick();
    regwen_stg = 2'b10;
    #1 chk("fwd_older", 32'(fwd_sel), 32'd2);
    tick();
    rd_stg = '0; regwen_stg = 2'b11;
    #1 chk("fwd_rd0", 32'(fwd_sel), 32'd0);
    tick();
    rs_ex = {5'd6, 5'd0}; rd_stg = {5'd0, 5'd6}; regwen_stg = 2'b11;
    #1 chk("fwd_op1", 32'(fwd_sel), 32'h4);
    tick();

    // Load-use
    idle_inputs();
    memrd_ex = 1'b1; regwen_ex = 1'b1; rd_ex = 5'd7; rs_id = {5'd7, 5'd0}; rs_used_id = 2'b10;
    #1 chk("lu_stall", 32'(stall_id), 32'd1);
    tick();
    chk("lu_cnt", 32'(stall_cnt), 32'd1);
    rs_used_id = 2'b00;
    #1 chk("lu_unused", 32'(stall_id), 32'd0);
    tick();

    // Scoreboard: issue x9, read it until completion at cycle 20
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    lat_issue = 1'b1; lat_issue_rd = 5'd9;
    tick();
    lat_issue = 1'b0; rs_id = {5'd0, 5'd9}; rs_used_id = 2'b01;
    for (int c = 1; c < 20; c++) tick();
    lat_done = 1'b1; lat_done_rd = 5'd9;
    #1 chk("sb_no_bypass", 32'(stall_id), 32'd1);
    tick();
    lat_done = 1'b0;
    #1;
    chk("sb_release", 32'(stall_id), 32'd0);
    chk("sb_cnt20", 32'(stall_cnt), 32'd20);
    chk("sb_cnt_sat", 32'(stall_cnt_s), 32'd15);
    tick();

    // Same-edge set/clear, and writes to x0
    idle_inputs();
    lat_issue = 1'b1; lat_issue_rd = 5'd3; lat_done = 1'b1; lat_done_rd = 5'd3;
    tick();
    chk("set_wins", 32'(pending[3]), 32'd1);
    lat_done = 1'b0; lat_issue_rd = 5'd0;
    tick();
    chk("x0_ignored", 32'(pending[0]), 32'd0);
    lat_issue = 1'b0; lat_done = 1'b1; lat_done_rd = 5'd3;
    tick();

    // Reset mid-stall
    idle_inputs();
    lat_issue = 1'b1; lat_issue_rd = 5'd9;
    tick();
    lat_issue = 1'b0; rs_id = {5'd9, 5'd0}; rs_used_id = 2'b10;
    tick();
    chk("pre_rst_pend", pending, 32'h200);
    reset = 1'b1;
    tick();
    chk("mid_rst_pend", pending, 32'd0);
    chk("mid_rst_cnt", 32'(stall_cnt), 32'd0);
    chk("mid_rst_stall", 32'(stall_id), 32'd0);
    reset = 1'b0;
    #1 chk("post_rst_stall", 32'(stall_id), 32'd0);
    tick();

    // Randomized traffic over a small register window for frequent hits
    for (int n = 0; n < 400; n++) begin
      reset        = ($urandom_range(0, 39) == 0);
      rs_ex        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rd_stg       = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      regwen_stg   = 2'($urandom);
      rs_id        = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rs_used_id   = 2'($urandom);
      rd_id        = 5'($urandom_range(0, 7));
      regwen_id    = 1'($urandom);
      rd_ex        = 5'($urandom_range(0, 7));
      memrd_ex     = ($urandom_range(0, 2) == 0);
      regwen_ex    = 1'($urandom);
      lat_issue    = ($urandom_range(0, 3) == 0);
      lat_issue_rd = 5'($urandom_range(0, 7));
      lat_done     = ($urandom_range(0, 2) == 0);
      lat_done_rd  = 5'($urandom_range(0, 7));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
